// File: rtl/log_product_accumulator.sv
// log_product_accumulator
// Sums BURST_LEN approximate products from log_multiplier1 into one unsigned,
// saturating result. Products flagged as coming from a zero operand count as 0.
// Input side accepts while accumulating; the finished result is then held
// with out_valid until the consumer takes it.
module log_product_accumulator #(
  parameter int PROD_W    = 34,
  parameter int ACC_W     = 40,
  parameter int BURST_LEN = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PROD_W-1:0]                in_product,
  input  logic                             in_zero1,
  input  logic                             in_zero2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_sum,
  output logic                             out_sat,
  output logic [$clog2(BURST_LEN+1)-1:0]   out_zero_cnt
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;
  logic              sat_q, sat_d;

  logic              accept;
  logic              release_res;
  logic              last_beat;
  logic              is_zero;
  logic [ACC_W:0]    term_ext;
  logic [ACC_W:0]    sum_full;

  // clear wins over everything, so nothing is accepted or released in that cycle
  assign accept      = (state_q == ACCUM) && in_valid && !clear;
  assign release_res = (state_q == HOLD) && out_ready && !clear;
  assign last_beat   = accept && (cnt_q == LAST_BEAT);
  assign is_zero     = in_zero1 | in_zero2;

  // One extra bit on the adder exposes the overflow used for clamping
  assign term_ext = is_zero ? '0 : (ACC_W+1)'(in_product);
  assign sum_full = {1'b0, acc_q} + term_ext;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: finish a burst on its last accept, leave HOLD on handshake
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last_beat)   state_d = HOLD;
        HOLD:    if (release_res) state_d = ACCUM;
        default:                  state_d = ACCUM;
      endcase
    end
  end

  // Outputs: handshake flags from state, result fields masked outside HOLD
  always_comb begin
    in_ready     = (state_q == ACCUM);
    out_valid    = (state_q == HOLD);
    out_sum      = out_valid ? acc_q      : '0;
    out_sat      = out_valid ? sat_q      : 1'b0;
    out_zero_cnt = out_valid ? zero_cnt_q : '0;
  end

  // Accumulator next-state: zero on clear/release, saturating add on accept
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    zero_cnt_d = zero_cnt_q;
    sat_d      = sat_q;
    if (clear || release_res) begin
      acc_d      = '0;
      cnt_d      = '0;
      zero_cnt_d = '0;
      sat_d      = 1'b0;
    end else if (accept) begin
      cnt_d      = cnt_q + CNT_W'(1);
      zero_cnt_d = zero_cnt_q + CNT_W'(is_zero);
      // once clamped the sum stays pinned at max until the burst ends
      if (sat_q || sum_full[ACC_W]) begin
        acc_d = ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_full[ACC_W-1:0];
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      zero_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      zero_cnt_q <= zero_cnt_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_log_product_accumulator.sv
// Bench for log_product_accumulator: two instances (default 40-bit and a 34-bit
// accumulator for saturation) share one stimulus stream. A reference model
// pushes expected burst results into a queue; a negedge monitor pops them when
// the DUT presents a result.
module tb_log_product_accumulator;

  localparam longint unsigned MAX40 = 64'h0000_00FF_FFFF_FFFF;
  localparam longint unsigned MAX34 = 64'h0000_0003_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [33:0] in_product;
  logic        in_zero1;
  logic        in_zero2;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [39:0] out_sum_a;
  logic [3:0]  out_zc_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [33:0] out_sum_b;
  logic [3:0]  out_zc_b;

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_mode = 1'b0;

  typedef struct {
    longint unsigned s40;
    bit              t40;
    longint unsigned s34;
    bit              t34;
    int              zc;
  } res_t;
  res_t sb[$];

  longint unsigned m40, m34;
  bit              ms40, ms34;
  int              mzc, mcnt;

  always #5 clk = ~clk;

  log_product_accumulator u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_product(in_product),
    .in_zero1(in_zero1), .in_zero2(in_zero2),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
    .out_sat(out_sat_a), .out_zero_cnt(out_zc_a)
  );

  log_product_accumulator #(.ACC_W(34)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_product(in_product),
    .in_zero1(in_zero1), .in_zero2(in_zero2),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_sat(out_sat_b), .out_zero_cnt(out_zc_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m40 = 0; m34 = 0; ms40 = 0; ms34 = 0; mzc = 0; mcnt = 0;
  endtask

  // Monitor/scoreboard: everything sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      sb.delete();
      chk("rst_valid", out_valid_a, 0);
      chk("rst_ready", in_ready_a, 1);
    end else begin
      chk("valid_ab", out_valid_b, out_valid_a);
      chk("ready_ab", in_ready_b, in_ready_a);
      if (out_valid_a) begin
        chk("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("sum40", out_sum_a, sb[0].s40);
          chk("sat40", out_sat_a, sb[0].t40);
          chk("sum34", out_sum_b, sb[0].s34);
          chk("sat34", out_sat_b, sb[0].t34);
          chk("zcnt",  out_zc_a,  sb[0].zc);
          if (clear || out_ready) begin
            $display("result: sum40=%0d sat40=%0d sum34=%0d sat34=%0d zc=%0d %s",
                     out_sum_a, out_sat_a, out_sum_b, out_sat_b, out_zc_a,
                     clear ? "discarded" : "taken");
            sb.delete(0);
          end
        end
      end else begin
        chk("idle_sum40", out_sum_a, 0);
        chk("idle_sum34", out_sum_b, 0);
        chk("idle_sat",   out_sat_b, 0);
        chk("idle_zc",    out_zc_a,  0);
      end
      if (clear) begin
        model_reset();
      end else if (in_valid && in_ready_a) begin
        longint unsigned t;
        t = (in_zero1 | in_zero2) ? 64'd0 : 64'(in_product);
        m40 += t;
        if (m40 > MAX40) begin m40 = MAX40; ms40 = 1; end
        m34 += t;
        if (m34 > MAX34) begin m34 = MAX34; ms34 = 1; end
        mzc  += int'(in_zero1 | in_zero2);
        mcnt += 1;
        if (mcnt == 8) begin
          sb.push_back('{s40: m40, t40: ms40, s34: m34, t34: ms34, zc: mzc});
          model_reset();
        end
      end
    end
  end

  // Present one product and hold it until accepted; called at posedge+1
  task automatic send(input logic [33:0] p, input logic z1, input logic z2);
    int k;
    in_valid = 1'b1; in_product = p; in_zero1 = z1; in_zero2 = z2;
    for (k = 0; k < 1000; k++) begin
      if (in_ready_a) break;
      @(posedge clk); #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 2) != 0);
    end
    chk("send_accepted", k < 1000, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_zero1 = 1'b0; in_zero2 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_product = '0;
    in_zero1 = 1'b0; in_zero2 = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_valid", out_valid_a, 0);
    chk("reset_ready", in_ready_a, 1);
    chk("reset_sum", out_sum_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1: async reset mid-burst after 3 accepts
    send(34'd5, 0, 0); send(34'd6, 0, 0); send(34'd7, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t1_valid", out_valid_a, 0);
    chk("t1_ready", in_ready_a, 1);
    chk("t1_sum", out_sum_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T2: 1..8 summed, result visible right after the 8th accept
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(34'(i), 0, 0);
    chk("t2_valid", out_valid_a, 1);
    chk("t2_sum", out_sum_a, 36);
    chk("t2_sat", out_sat_a, 0);
    chk("t2_zc", out_zc_a, 0);
    tick();
    chk("t2_released", out_valid_a, 0);
    chk("t2_ready_after", in_ready_a, 1);

    // T3: zero flags on beats 2, 5 (zero1) and 7 (zero2)
    out_ready = 1'b0;
    for (int b = 1; b <= 8; b++) send(34'd1000, (b == 2) || (b == 5), b == 7);
    chk("t3_sum", out_sum_a, 5000);
    chk("t3_zc", out_zc_a, 3);
    out_ready = 1'b1;
    tick();

    // T4: saturation on the 34-bit instance, then a clean burst of 1s
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(34'h2_0000_0000, 0, 0);
    chk("t4_sum34", out_sum_b, 64'h3_FFFF_FFFF);
    chk("t4_sat34", out_sat_b, 1);
    chk("t4_sum40", out_sum_a, 64'h10_0000_0000);
    chk("t4_sat40", out_sat_a, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(34'd1, 0, 0);
    chk("t4_next_sum34", out_sum_b, 8);
    chk("t4_next_sat34", out_sat_b, 0);
    out_ready = 1'b1;
    tick();

    // T5: backpressure for 5 cycles with a product waiting, then random traffic
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(34'(3 * i), 0, 0);
    in_valid = 1'b1; in_product = 34'd99;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_ready_hold", in_ready_a, 0);
      chk("t5_valid_hold", out_valid_a, 1);
      chk("t5_sum_stable", out_sum_a, 108);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    rnd_mode = 1'b1;
    for (int n = 0; n < 800; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) r = r >> $urandom_range(0, 30);
      send(r[33:0], $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    chk("t5_drained", sb.size(), 0);

    // T6: clear after 4 accepts drops the partial sum and the presented product
    for (int i = 0; i < 4; i++) send(34'd7, 0, 0);
    clear = 1'b1; in_valid = 1'b1; in_product = 34'd1234;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("t6_ready", in_ready_a, 1);
    chk("t6_valid", out_valid_a, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(34'd2, 0, 0);
    chk("t6_sum_a", out_sum_a, 16);
    out_ready = 1'b1;
    tick();
    // clear while holding a result discards it
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(34'd9, 0, 0);
    chk("t6_hold_valid", out_valid_a, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clear_valid", out_valid_a, 0);
    chk("t6_clear_ready", in_ready_a, 1);
    chk("t6_clear_sum", out_sum_a, 0);
    for (int i = 0; i < 8; i++) send(34'd2, 0, 0);
    chk("t6_sum_b", out_sum_a, 16);
    out_ready = 1'b1;
    tick(); tick();
    chk("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
